// File: rtl/wb_fib_regs.sv
`default_nettype none
// ============================================================================
// Module   : wb_fib_regs
// Purpose  : Wishbone register block for a bank of Fibonacci channels.
//            Holds channel enables, clock selects and thresholds, and raises
//            a latched interrupt when a channel value first reaches its
//            threshold (snapshotting the value at that moment).
// Revision : 1.0 - initial release
// ============================================================================
module wb_fib_regs #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
  parameter int          NUM_CH       = 2,   // 1..4
  parameter int          VAL_WIDTH    = 30,  // 1..32
  parameter int          CLOCK_WIDTH  = 6    // 1..32
) (
  input  logic                            wb_clk_i,
  input  logic                            wb_rst_ni,
  input  logic                            wbs_stb_i,
  input  logic                            wbs_cyc_i,
  input  logic                            wbs_we_i,
  input  logic [3:0]                      wbs_sel_i,
  input  logic [31:0]                     wbs_adr_i,
  input  logic [31:0]                     wbs_dat_i,
  output logic                            wbs_ack_o,
  output logic [31:0]                     wbs_dat_o,
  input  logic [NUM_CH*VAL_WIDTH-1:0]     ch_val_i,
  output logic [NUM_CH-1:0]               ch_en_o,
  output logic [NUM_CH*CLOCK_WIDTH-1:0]   clock_sel_o,
  output logic [2:0]                      irq_o
);

  localparam logic [31:0] c_id        = 32'h4669_626F;
  localparam logic [31:0] c_cfg       = {8'h02, 8'(CLOCK_WIDTH), 8'(VAL_WIDTH), 8'(NUM_CH)};
  localparam logic [31:0] c_win_bytes = 32'(32'h20 + 32'h10 * NUM_CH);

  localparam logic [0:0]  c_st_idle   = 1'b0;
  localparam logic [0:0]  c_st_ack    = 1'b1;

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0]                              r_rst_sync;
  logic                                    w_rst_n;

  logic [0:0]                              r_state;
  logic [0:0]                              w_state_nxt;
  logic [31:0]                             r_rdata;

  logic [NUM_CH-1:0]                       r_ctrl;
  logic [NUM_CH-1:0]                       r_mask;
  logic [NUM_CH-1:0]                       r_status;
  logic [NUM_CH-1:0]                       r_ge;
  logic [31:0]                             r_scratch;
  logic [NUM_CH-1:0][CLOCK_WIDTH-1:0]      r_clk;
  logic [NUM_CH-1:0][VAL_WIDTH-1:0]        r_thresh;
  logic [NUM_CH-1:0][VAL_WIDTH-1:0]        r_snap;
  logic [2:0]                              r_irq;

  logic [NUM_CH-1:0][VAL_WIDTH-1:0]        w_val;
  logic [31:0]                             w_off;
  logic                                    w_in_win;
  logic                                    w_in_ch;
  logic [3:0]                              w_chsel;
  logic [2:0]                              w_reg_sel;
  logic                                    w_access;
  logic                                    w_wr;
  logic                                    w_wr_glb;
  logic [31:0]                             w_bmask;
  logic [31:0]                             w_rdata;
  logic [NUM_CH-1:0]                       w_hit;
  logic [NUM_CH-1:0]                       w_evt;
  logic [NUM_CH-1:0]                       w_clr;
  logic [NUM_CH-1:0]                       w_status_nxt;
  logic [NUM_CH-1:0]                       w_mask_nxt;

  // --------------------------------------------------------------------------
  // Reset: asserted asynchronously, released on the second clock edge
  // --------------------------------------------------------------------------
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end

  assign w_rst_n = r_rst_sync[1];

  // --------------------------------------------------------------------------
  // Address decode. Addresses below the base wrap to a huge offset and so
  // fall outside the window as well.
  // --------------------------------------------------------------------------
  assign w_val     = ch_val_i;
  assign w_off     = wbs_adr_i - BASE_ADDRESS;
  assign w_in_win  = (w_off < c_win_bytes);
  assign w_in_ch   = (w_off[7:5] != 3'd0);
  assign w_chsel   = w_off[7:4] - 4'd2;
  assign w_reg_sel = w_off[4:2];
  assign w_access  = (r_state == c_st_idle) & wbs_stb_i & wbs_cyc_i & w_in_win;
  assign w_wr      = w_access & wbs_we_i;
  assign w_wr_glb  = w_wr & ~w_in_ch;
  assign w_bmask   = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                      {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};

  // Handshake state register
  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= c_st_idle;
    else          r_state <= w_state_nxt;
  end

  // Handshake next state: every accepted access is followed by one ACK cycle
  always_comb begin
    w_state_nxt = c_st_idle;
    if (r_state == c_st_idle && w_access) w_state_nxt = c_st_ack;
  end

  // Handshake outputs: read data is only visible while acknowledging
  always_comb begin
    wbs_ack_o = (r_state == c_st_ack);
    wbs_dat_o = (r_state == c_st_ack) ? r_rdata : 32'd0;
  end

  // Read mux; unmapped in-window words return zero
  always_comb begin
    w_rdata = 32'd0;
    if (!w_in_ch) begin
      case (w_reg_sel)
        3'd0:    w_rdata = c_id;
        3'd1:    w_rdata = c_cfg;
        3'd2:    w_rdata = 32'(r_ctrl);
        3'd3:    w_rdata = 32'(r_status);
        3'd4:    w_rdata = 32'(r_mask);
        3'd5:    w_rdata = r_scratch;
        default: w_rdata = 32'd0;
      endcase
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_chsel == 4'(c)) begin
          case (w_off[3:2])
            2'd0:    w_rdata = 32'(r_clk[c]);
            2'd1:    w_rdata = 32'(w_val[c]);
            2'd2:    w_rdata = 32'(r_thresh[c]);
            default: w_rdata = 32'(r_snap[c]);
          endcase
        end
      end
    end
  end

  // Threshold detection and interrupt status next-state (event beats clear)
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      w_hit[c] = r_ctrl[c] & (w_val[c] >= r_thresh[c]);
    end
    w_evt        = w_hit & ~r_ge;
    w_clr        = (w_wr_glb && w_reg_sel == 3'd3 && wbs_sel_i[0]) ?
                   wbs_dat_i[NUM_CH-1:0] : '0;
    w_status_nxt = (r_status & ~w_clr) | w_evt;
    w_mask_nxt   = (w_wr_glb && w_reg_sel == 3'd4) ?
                   ((r_mask & ~w_bmask[NUM_CH-1:0]) |
                    (wbs_dat_i[NUM_CH-1:0] & w_bmask[NUM_CH-1:0])) : r_mask;
  end

  // Global registers and the captured read data
  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ctrl    <= '1;
      r_scratch <= 32'd0;
      r_rdata   <= 32'd0;
    end else begin
      if (w_access) r_rdata <= wbs_we_i ? 32'd0 : w_rdata;
      if (w_wr_glb && w_reg_sel == 3'd2)
        r_ctrl <= (r_ctrl & ~w_bmask[NUM_CH-1:0]) |
                  (wbs_dat_i[NUM_CH-1:0] & w_bmask[NUM_CH-1:0]);
      if (w_wr_glb && w_reg_sel == 3'd5)
        r_scratch <= (r_scratch & ~w_bmask) | (wbs_dat_i & w_bmask);
    end
  end

  // Per-channel configuration registers (clock select, threshold)
  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        r_clk[c]    <= CLOCK_WIDTH'(1);
        r_thresh[c] <= '1;
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr && w_in_ch && w_chsel == 4'(c) && w_off[3:2] == 2'd0)
          r_clk[c] <= (r_clk[c] & ~w_bmask[CLOCK_WIDTH-1:0]) |
                      (wbs_dat_i[CLOCK_WIDTH-1:0] & w_bmask[CLOCK_WIDTH-1:0]);
        if (w_wr && w_in_ch && w_chsel == 4'(c) && w_off[3:2] == 2'd2)
          r_thresh[c] <= (r_thresh[c] & ~w_bmask[VAL_WIDTH-1:0]) |
                         (wbs_dat_i[VAL_WIDTH-1:0] & w_bmask[VAL_WIDTH-1:0]);
      end
    end
  end

  // Threshold tracking, snapshots, status/mask and registered interrupts
  always_ff @(posedge wb_clk_i or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ge     <= '0;
      r_status <= '0;
      r_mask   <= '0;
      r_irq    <= 3'd0;
      for (int c = 0; c < NUM_CH; c++) r_snap[c] <= '0;
    end else begin
      // A disabled channel has w_hit low, so ge clears and re-enable re-fires
      r_ge     <= w_hit;
      r_status <= w_status_nxt;
      r_mask   <= w_mask_nxt;
      r_irq    <= {1'b0, |w_status_nxt, |(w_status_nxt & w_mask_nxt)};
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_evt[c]) r_snap[c] <= w_val[c];
      end
    end
  end

  assign ch_en_o     = r_ctrl;
  assign clock_sel_o = r_clk;
  assign irq_o       = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_wb_fib_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_fib_regs
// Purpose  : Directed, table-driven bench for wb_fib_regs (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wb_fib_regs;

  localparam logic [31:0] BASE = 32'h3000_0000;
  localparam int          NV   = 31;
  localparam int          NRST = 12;

  typedef struct {
    bit          we;
    logic [31:0] off;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic [31:0] exp;
    string       name;
  } vec_t;

  logic        wb_clk_i  = 1'b0;
  logic        wb_rst_ni = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_we_i  = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'd0;
  logic [31:0] wbs_dat_i = 32'd0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [59:0] ch_val_i  = 60'd0;
  logic [1:0]  ch_en_o;
  logic [11:0] clock_sel_o;
  logic [2:0]  irq_o;

  int   n_checks = 0;
  int   n_errors = 0;
  vec_t vecs [0:NV-1];

  wb_fib_regs dut (
    .wb_clk_i    (wb_clk_i),
    .wb_rst_ni   (wb_rst_ni),
    .wbs_stb_i   (wbs_stb_i),
    .wbs_cyc_i   (wbs_cyc_i),
    .wbs_we_i    (wbs_we_i),
    .wbs_sel_i   (wbs_sel_i),
    .wbs_adr_i   (wbs_adr_i),
    .wbs_dat_i   (wbs_dat_i),
    .wbs_ack_o   (wbs_ack_o),
    .wbs_dat_o   (wbs_dat_o),
    .ch_val_i    (ch_val_i),
    .ch_en_o     (ch_en_o),
    .clock_sel_o (clock_sel_o),
    .irq_o       (irq_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input bit we, input logic [31:0] off,
                         input logic [31:0] dat, input logic [3:0] sel,
                         input logic [31:0] exp, input string name);
    vecs[i].we   = we;
    vecs[i].off  = off;
    vecs[i].dat  = dat;
    vecs[i].sel  = sel;
    vecs[i].exp  = exp;
    vecs[i].name = name;
  endtask

  // One bus transfer, started #1 after a rising edge; waits at most 4 cycles
  task automatic wb_xfer(input bit we, input logic [31:0] off, input logic [31:0] dat,
                         input logic [3:0] sel, output logic [31:0] rdat, output bit got);
    wbs_adr_i = BASE + off;
    wbs_dat_i = dat;
    wbs_sel_i = sel;
    wbs_we_i  = we;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    got  = 1'b0;
    rdat = 32'd0;
    for (int n = 0; n < 4 && !got; n++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        got  = 1'b1;
        rdat = wbs_dat_o;
      end
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    wbs_we_i  = 1'b0;
  endtask

  task automatic xfer_chk(input bit we, input logic [31:0] off, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    bit          got;
    wb_xfer(we, off, dat, sel, rd, got);
    chk({name, "_ack"}, 32'(got), 32'd1);
    chk(name, rd, exp);
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      xfer_chk(vecs[i].we, vecs[i].off, vecs[i].dat, vecs[i].sel, vecs[i].exp, vecs[i].name);
      @(posedge wb_clk_i); #1;
      chk({vecs[i].name, "_pulse"}, 32'(wbs_ack_o), 32'd0);
    end
  endtask

  // Hold a read request for a number of cycles and count acknowledges
  task automatic hold_count(input logic [31:0] addr, input int cycles,
                            output int acks, output bit consec);
    bit prev;
    prev   = 1'b0;
    acks   = 0;
    consec = 1'b0;
    wbs_adr_i = addr;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'hF;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    for (int n = 0; n < cycles; n++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) acks++;
      if (wbs_ack_o && prev) consec = 1'b1;
      prev = wbs_ack_o;
    end
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ack"},   32'(wbs_ack_o),   32'd0);
    chk({tag, "_dat"},   wbs_dat_o,        32'd0);
    chk({tag, "_irq"},   32'(irq_o),       32'd0);
    chk({tag, "_en"},    32'(ch_en_o),     32'd3);
    chk({tag, "_clk"},   32'(clock_sel_o), 32'h041);
  endtask

  initial begin
    int          acks;
    bit          consec;
    logic [31:0] rd;
    bit          got;

    // Reset values (indices 0..NRST-1 are reused after the mid-run reset)
    set_vec( 0, 0, 32'h00, 32'h0,        4'hF, 32'h4669626F, "id");
    set_vec( 1, 0, 32'h04, 32'h0,        4'hF, 32'h02061E02, "cfg");
    set_vec( 2, 0, 32'h08, 32'h0,        4'hF, 32'h00000003, "ctrl_rst");
    set_vec( 3, 0, 32'h0C, 32'h0,        4'hF, 32'h00000000, "status_rst");
    set_vec( 4, 0, 32'h10, 32'h0,        4'hF, 32'h00000000, "mask_rst");
    set_vec( 5, 0, 32'h14, 32'h0,        4'hF, 32'h00000000, "scratch_rst");
    set_vec( 6, 0, 32'h20, 32'h0,        4'hF, 32'h00000001, "clk0_rst");
    set_vec( 7, 0, 32'h30, 32'h0,        4'hF, 32'h00000001, "clk1_rst");
    set_vec( 8, 0, 32'h28, 32'h0,        4'hF, 32'h3FFFFFFF, "thr0_rst");
    set_vec( 9, 0, 32'h38, 32'h0,        4'hF, 32'h3FFFFFFF, "thr1_rst");
    set_vec(10, 0, 32'h2C, 32'h0,        4'hF, 32'h00000000, "snap0_rst");
    set_vec(11, 0, 32'h3C, 32'h0,        4'hF, 32'h00000000, "snap1_rst");
    // Byte lanes, field widths, RO/unmapped handling, live values
    set_vec(12, 1, 32'h14, 32'hAABBCCDD, 4'h5, 32'h00000000, "wr_scratch");
    set_vec(13, 0, 32'h14, 32'h0,        4'hF, 32'h00BB00DD, "rd_scratch");
    set_vec(14, 1, 32'h30, 32'hFFFFFFFF, 4'h1, 32'h00000000, "wr_clk1");
    set_vec(15, 0, 32'h30, 32'h0,        4'hF, 32'h0000003F, "rd_clk1");
    set_vec(16, 1, 32'h00, 32'h12345678, 4'hF, 32'h00000000, "wr_id");
    set_vec(17, 0, 32'h00, 32'h0,        4'hF, 32'h4669626F, "rd_id_ro");
    set_vec(18, 0, 32'h18, 32'h0,        4'hF, 32'h00000000, "rd_unmapped");
    set_vec(19, 1, 32'h08, 32'hFFFFFFFE, 4'hF, 32'h00000000, "wr_ctrl");
    set_vec(20, 0, 32'h08, 32'h0,        4'hF, 32'h00000002, "rd_ctrl");
    set_vec(21, 1, 32'h08, 32'h00000101, 4'h2, 32'h00000000, "wr_ctrl_b1");
    set_vec(22, 0, 32'h08, 32'h0,        4'hF, 32'h00000002, "rd_ctrl_b1");
    set_vec(23, 1, 32'h38, 32'h12345678, 4'hC, 32'h00000000, "wr_thr1");
    set_vec(24, 0, 32'h38, 32'h0,        4'hF, 32'h1234FFFF, "rd_thr1");
    set_vec(25, 0, 32'h24, 32'h0,        4'hF, 32'h00000005, "rd_val0");
    set_vec(26, 0, 32'h34, 32'h0,        4'hF, 32'h00000007, "rd_val1");
    set_vec(27, 1, 32'h08, 32'h00000003, 4'h1, 32'h00000000, "wr_ctrl_on");
    set_vec(28, 0, 32'h08, 32'h0,        4'hF, 32'h00000003, "rd_ctrl_on");
    set_vec(29, 1, 32'h1C, 32'hFFFFFFFF, 4'hF, 32'h00000000, "wr_unmapped");
    set_vec(30, 0, 32'h1C, 32'h0,        4'hF, 32'h00000000, "rd_unmapped2");

    // Power-on reset
    repeat (3) @(posedge wb_clk_i);
    #1;
    chk_reset_outputs("por");
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    repeat (4) @(posedge wb_clk_i);
    #1;

    ch_val_i[29:0]  = 30'd5;
    ch_val_i[59:30] = 30'd7;
    run_vecs(0, NV - 1);
    chk("clock_sel_out", 32'(clock_sel_o), 32'hFC1);
    chk("ch_en_out",     32'(ch_en_o),     32'd3);

    // Threshold crossing 99 -> 100 -> 101 on channel 0
    ch_val_i[29:0] = 30'd99;
    xfer_chk(1, 32'h28, 32'd100, 4'hF, 32'd0, "wr_thr0");
    repeat (2) @(posedge wb_clk_i);
    #1;
    chk("irq_below", 32'(irq_o), 32'd0);
    ch_val_i[29:0] = 30'd100;
    @(posedge wb_clk_i); #1;
    chk("irq_event", 32'(irq_o), 32'b010);
    ch_val_i[29:0] = 30'd101;
    repeat (3) @(posedge wb_clk_i);
    #1;
    xfer_chk(0, 32'h0C, 32'd0, 4'hF, 32'd1,   "status_once");
    xfer_chk(0, 32'h2C, 32'd0, 4'hF, 32'd100, "snap0_100");
    xfer_chk(1, 32'h10, 32'd1, 4'hF, 32'd0,   "wr_mask");
    chk("irq_masked_in", 32'(irq_o), 32'b011);

    // Clear colliding with a fresh event: the event wins
    ch_val_i[29:0] = 30'd50;
    repeat (2) @(posedge wb_clk_i);
    #1;
    ch_val_i[29:0] = 30'd150;
    xfer_chk(1, 32'h0C, 32'd1, 4'h1, 32'd0,   "w1c_collide");
    xfer_chk(0, 32'h0C, 32'd0, 4'hF, 32'd1,   "set_wins");
    xfer_chk(0, 32'h2C, 32'd0, 4'hF, 32'd150, "snap0_150");
    xfer_chk(1, 32'h0C, 32'd1, 4'h1, 32'd0,   "w1c_clear");
    @(posedge wb_clk_i); #1;
    chk("irq_cleared", 32'(irq_o), 32'd0);
    xfer_chk(0, 32'h0C, 32'd0, 4'hF, 32'd0,   "status_cleared");

    // Disable then re-enable above threshold produces a new event
    xfer_chk(1, 32'h08, 32'd2, 4'h1, 32'd0, "ch0_off");
    xfer_chk(1, 32'h08, 32'd3, 4'h1, 32'd0, "ch0_on");
    @(posedge wb_clk_i); #1;
    xfer_chk(0, 32'h0C, 32'd0, 4'hF, 32'd1, "reenable_event");
    chk("irq_reenable", 32'(irq_o), 32'b011);

    // Window boundaries and back-to-back request rate
    hold_count(BASE - 32'd4, 6, acks, consec);
    chk("below_base_acks", 32'(acks), 32'd0);
    hold_count(BASE + 32'h60, 6, acks, consec);
    chk("above_win_acks", 32'(acks), 32'd0);
    hold_count(BASE + 32'h14, 8, acks, consec);
    chk("held_acks", 32'(acks), 32'd4);
    chk("held_no_b2b", 32'(consec), 32'd0);
    @(posedge wb_clk_i); #1;

    // Reset asserted in the middle of an ACK cycle
    wbs_adr_i = BASE + 32'h14;
    wbs_we_i  = 1'b0;
    wbs_sel_i = 4'hF;
    wbs_stb_i = 1'b1;
    wbs_cyc_i = 1'b1;
    @(posedge wb_clk_i); #1;
    chk("ack_before_rst", 32'(wbs_ack_o), 32'd1);
    #2;
    wb_rst_ni = 1'b0;
    #1;
    chk("ack_in_rst", 32'(wbs_ack_o), 32'd0);
    chk("dat_in_rst", wbs_dat_o, 32'd0);
    wbs_stb_i = 1'b0;
    wbs_cyc_i = 1'b0;
    repeat (2) @(posedge wb_clk_i);
    #1;
    chk_reset_outputs("mid");
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    repeat (4) @(posedge wb_clk_i);
    #1;
    run_vecs(0, NRST - 1);
    wb_xfer(0, 32'h24, 32'd0, 4'hF, rd, got);
    chk("val0_after_rst", rd, 32'd150);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running, expected finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/wb_fib_regs.md
WB_FIB_REGS -- requirements
Module: wb_fib_regs

Interface
REQ-001 SHALL have parameter BASE_ADDRESS, default 32'h3000_0000, Wishbone window base.
REQ-002 SHALL have parameter NUM_CH, default 2, legal range 1..4, number of Fibonacci channels.
REQ-003 SHALL have parameter VAL_WIDTH, default 30, legal range 1..32, per-channel value width.
REQ-004 SHALL have parameter CLOCK_WIDTH, default 6, per-channel clock-select width.
REQ-005 SHALL have ports as listed below; the first two are the clock and reset.
- wb_clk_i  in  1  the only clock; all logic on its rising edge.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe, cycle, write-enable.
- wbs_sel_i  in  4  byte-lane selects.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  registered acknowledge.
- wbs_dat_o  out  32  read data.
- ch_val_i  in  NUM_CH*VAL_WIDTH  channel values; channel c at [c*VAL_WIDTH +: VAL_WIDTH].
- ch_en_o  out  NUM_CH  channel enables.
- clock_sel_o  out  NUM_CH*CLOCK_WIDTH  per-channel clock selects.
- irq_o  out  3  interrupt lines.

Function
REQ-006 Register map, as offsets from BASE_ADDRESS, SHALL be:
- 0x00 ID: RO, 32'h4669_626F.
- 0x04 CFG: RO, {8'h02, CLOCK_WIDTH[7:0], VAL_WIDTH[7:0], NUM_CH[7:0]}.
- 0x08 CTRL: RW, bits [NUM_CH-1:0] drive ch_en_o.
- 0x0C IRQ_STATUS: W1C.
- 0x10 IRQ_MASK: RW, width NUM_CH.
- 0x14 SCRATCH: RW, 32 bits.
- Per channel c, with B = 0x20 + 0x10*c:
  - B+0x0 CLK: RW, drives clock_sel_o slice c.
  - B+0x4 VAL: RO, live ch_val_i slice c.
  - B+0x8 THRESH: RW, VAL_WIDTH bits.
  - B+0xC SNAP: RO, value captured at the last threshold event.
REQ-007 Window SHALL be BASE_ADDRESS to BASE_ADDRESS + 0x20 + 0x10*NUM_CH - 1; addresses outside it SHALL never be acknowledged.
REQ-008 Handshake: 2-state FSM IDLE/ACK.
- IDLE to ACK when stb&cyc and the address is in the window.
- ACK to IDLE unconditionally.
- wbs_ack_o is high only in ACK, as a one-cycle pulse.
- At most one transfer per 2 cycles.
REQ-009 Register reads and writes SHALL take effect on the IDLE-to-ACK edge, using the address and data sampled in that cycle.
REQ-010 wbs_dat_o SHALL carry the read data during the ACK cycle of a read and be 0 at all other times.
REQ-011 Field width: unused upper bits read 0, and narrow fields take their low-order bits from wbs_dat_i.
REQ-012 Writes to RW registers SHALL update only the bytes whose wbs_sel_i bit is set.
REQ-013 Writes to RO or unmapped in-window addresses SHALL be acknowledged and ignored, and reads of unmapped in-window addresses SHALL return 0.
REQ-014 Each channel SHALL keep a registered flag ge[c], equal to ch_en[c] & (val >= thresh) from the previous cycle.
REQ-015 A threshold event SHALL fire for channel c when ch_en[c] & (val >= thresh) & !ge[c].
- Sets IRQ_STATUS[c].
- Loads SNAP[c] with the current value.
REQ-016 A W1C write SHALL clear the IRQ_STATUS bits written as 1 with wbs_sel_i[0] set; if an event and a clear hit the same bit in the same cycle, set wins.
REQ-017 Disabling channel c SHALL clear ge[c], so re-enabling while val >= thresh produces a new event.
REQ-018 Interrupt outputs, all registered, SHALL be:
- irq_o[0] = |(IRQ_STATUS & IRQ_MASK).
- irq_o[1] = |IRQ_STATUS.
- irq_o[2] = 0.
REQ-019 Value comparison SHALL be unsigned over VAL_WIDTH bits.

Reset
REQ-020 While wb_rst_ni is low, and asynchronously on its falling edge, all state SHALL reset:
- FSM to IDLE; wbs_ack_o = 0; wbs_dat_o = 0.
- CTRL = all ones (ch_en_o all 1).
- Each CLK = 1.
- Each THRESH = all ones.
- SNAP, IRQ_STATUS, IRQ_MASK, SCRATCH and ge = 0; irq_o = 0.
REQ-021 Reset during ACK SHALL drop the ack immediately and discard the transfer.
REQ-022 Reset deassertion SHALL be synchronised to wb_clk_i (assert asynchronously, release synchronously).

Verification
REQ-023 Read at BASE+0x00, then BASE+0x04 with NUM_CH=2 -> one-cycle ack each, data 32'h4669626F, then 32'h02061E02.
REQ-024 Write 32'hAABBCCDD to SCRATCH with sel=4'b0101, then read -> 32'h00BB00DD.
REQ-025 THRESH0 = 100, ch_val ramps 99 -> 100 -> 101 -> IRQ_STATUS[0] set once, SNAP0 = 100, irq_o[1] = 1; irq_o[0] = 1 only after IRQ_MASK[0] is written.
REQ-026 Write 1 to IRQ_STATUS[0] in the same cycle as a new event on channel 0 -> bit stays 1; next clear with no event -> 0, irq_o = 0.
REQ-027 stb&cyc held at BASE-4, then at BASE+0x60 (NUM_CH=2) -> wbs_ack_o stays 0; held at BASE+0x14 -> acks on alternate cycles.
REQ-028 wb_rst_ni pulsed low during an ACK cycle -> ack is 0 in the same cycle, and all registers read back their reset values.
